alu_regfile_unit: RTL and testbench

//  Execute core of the single-cycle RV32I datapath: a 32-entry register file plus ALU.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_core.sv | 51 +++++
 rtl/alu_regfile_unit.sv | 91 +++++++++
 tb/tb_alu_regfile_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared ALU definitions for the RV32I datapath. Holds the alu_op encodings
//   used by both the control unit (which produces alu_op) and the execute
//   stage (which decodes it), so the two can never drift apart.
//   Ports: none (package only).
package alu_pkg;

  localparam int unsigned DATAWIDTH = 32;
  localparam int unsigned OPWIDTH   = 4;
  localparam int unsigned SHAMTW    = 5;

  localparam logic [OPWIDTH-1:0] ALU_AND  = 4'b0000;
  localparam logic [OPWIDTH-1:0] ALU_OR   = 4'b0001;
  localparam logic [OPWIDTH-1:0] ALU_ADD  = 4'b0010;
  localparam logic [OPWIDTH-1:0] ALU_SUB  = 4'b0110;
  localparam logic [OPWIDTH-1:0] ALU_SLT  = 4'b0100;
  localparam logic [OPWIDTH-1:0] ALU_SLTU = 4'b0101;
  localparam logic [OPWIDTH-1:0] ALU_XOR  = 4'b1101;
  localparam logic [OPWIDTH-1:0] ALU_SRL  = 4'b1000;
  localparam logic [OPWIDTH-1:0] ALU_SLL  = 4'b1001;
  localparam logic [OPWIDTH-1:0] ALU_SRA  = 4'b1010;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// alu_core
//   Purely combinational ALU for the execute stage.
//   Ports:
//     op1    in   DATAWIDTH  first operand (rs1 contents)
//     op2    in   DATAWIDTH  second operand (rs2 or immediate)
//     alu_op in   4          operation select, see alu_pkg
//     result out  DATAWIDTH  operation result, 0 for unknown codes
//     zero   out  1          high when result is all zeros
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned DATAWIDTH = alu_pkg::DATAWIDTH
) (
  input  logic [DATAWIDTH-1:0] op1,
  input  logic [DATAWIDTH-1:0] op2,
  input  logic [OPWIDTH-1:0]   alu_op,
  output logic [DATAWIDTH-1:0] result,
  output logic                 zero
);

  // Only the low five bits of op2 form the shift amount, matching RV32I.
  logic [SHAMTW-1:0] shamt;
  logic              sltFlag;
  logic              sltuFlag;

  assign shamt    = op2[SHAMTW-1:0];
  assign sltFlag  = ($signed(op1) < $signed(op2));
  assign sltuFlag = (op1 < op2);

  // Operation decode. Unknown codes fall through to zero so the branch
  // logic sees zero=1 rather than garbage.
  always_comb begin
    result = '0;
    unique case (alu_op)
      ALU_AND:  result = op1 & op2;
      ALU_OR:   result = op1 | op2;
      ALU_ADD:  result = op1 + op2;
      ALU_SUB:  result = op1 - op2;
      ALU_SLT:  result = {{(DATAWIDTH-1){1'b0}}, sltFlag};
      ALU_SLTU: result = {{(DATAWIDTH-1){1'b0}}, sltuFlag};
      ALU_XOR:  result = op1 ^ op2;
      ALU_SRL:  result = op1 >> shamt;
      ALU_SLL:  result = op1 << shamt;
      ALU_SRA:  result = $unsigned($signed(op1) >>> shamt);
      default:  result = '0;
    endcase
  end

  assign zero = (result == {DATAWIDTH{1'b0}});

endmodule : alu_core

// File: rtl/alu_regfile_unit.sv
// alu_regfile_unit
//   Execute core of the single-cycle RV32I datapath: 32-entry register file
//   with write-first bypass, op2 select mux, and the ALU.
//   Ports:
//     clk        in   1          rising-edge clock
//     rst        in   1          asynchronous active-high reset, clears regs
//     readReg1   in   5          rs1 address
//     readReg2   in   5          rs2 address
//     writeReg   in   5          rd address
//     writeData  in   DATAWIDTH  rd write data
//     write      in   1          register write enable
//     ALUSrc     in   1          1 selects imm as op2, 0 selects readData2
//     imm        in   DATAWIDTH  sign-extended immediate
//     alu_op     in   4          ALU operation code
//     readData1  out  DATAWIDTH  rs1 contents (bypassed)
//     readData2  out  DATAWIDTH  rs2 contents (bypassed)
//     result     out  DATAWIDTH  ALU result / data address
//     zero       out  1          result == 0
module alu_regfile_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATAWIDTH = alu_pkg::DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           readReg1,
  input  logic [4:0]           readReg2,
  input  logic [4:0]           writeReg,
  input  logic [DATAWIDTH-1:0] writeData,
  input  logic                 write,
  input  logic                 ALUSrc,
  input  logic [DATAWIDTH-1:0] imm,
  input  logic [OPWIDTH-1:0]   alu_op,
  output logic [DATAWIDTH-1:0] readData1,
  output logic [DATAWIDTH-1:0] readData2,
  output logic [DATAWIDTH-1:0] result,
  output logic                 zero
);

  logic [DATAWIDTH-1:0] regs_q [32];
  logic                 wrEn_d;
  logic [DATAWIDTH-1:0] op2;

  // x0 is never written, so its flop stays at the reset value of zero.
  assign wrEn_d = write && (writeReg != 5'd0);

  // Register array. Reset is asynchronous and wins over any write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wrEn_d) begin
      regs_q[writeReg] <= writeData;
    end
  end

  // Read ports. A write to the same register in this cycle is forwarded
  // (write-first) so a consumer in the same cycle sees the new value;
  // x0 reads are forced to zero independently of the array.
  always_comb begin
    readData1 = regs_q[readReg1];
    if (readReg1 == 5'd0) begin
      readData1 = '0;
    end else if (wrEn_d && (writeReg == readReg1)) begin
      readData1 = writeData;
    end
  end

  always_comb begin
    readData2 = regs_q[readReg2];
    if (readReg2 == 5'd0) begin
      readData2 = '0;
    end else if (wrEn_d && (writeReg == readReg2)) begin
      readData2 = writeData;
    end
  end

  assign op2 = ALUSrc ? imm : readData2;

  alu_core #(
    .DATAWIDTH(DATAWIDTH)
  ) u_alu_core (
    .op1   (readData1),
    .op2   (op2),
    .alu_op(alu_op),
    .result(result),
    .zero  (zero)
  );

endmodule : alu_regfile_unit

// File: tb/tb_alu_regfile_unit.sv
// tb_alu_regfile_unit
//   Directed self-checking bench for alu_regfile_unit. Inputs change one
//   time unit after the rising edge; outputs are sampled shortly afterwards,
//   well away from the next edge.
module tb_alu_regfile_unit;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;

  logic        clk;
  logic        rst;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        write;
  logic        ALUSrc;
  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] result;
  logic        zero;

  int compared   = 0;
  int mismatched = 0;

  alu_regfile_unit dut (
    .clk      (clk),
    .rst      (rst),
    .readReg1 (readReg1),
    .readReg2 (readReg2),
    .writeReg (writeReg),
    .writeData(writeData),
    .write    (write),
    .ALUSrc   (ALUSrc),
    .imm      (imm),
    .alu_op   (alu_op),
    .readData1(readData1),
    .readData2(readData2),
    .result   (result),
    .zero     (zero)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck run still terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drive operand selection and ALU op, then let combinational logic settle
  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic src, input logic [31:0] immVal,
                               input logic [3:0] op);
    readReg1 = rs1;
    readReg2 = rs2;
    ALUSrc   = src;
    imm      = immVal;
    alu_op   = op;
    #1;
  endtask

  // One clocked register write, write enable dropped right after the edge
  task automatic regWrite(input logic [4:0] rd, input logic [31:0] data);
    writeReg  = rd;
    writeData = data;
    write     = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    readReg1  = 5'd5;
    readReg2  = 5'd0;
    writeReg  = 5'd0;
    writeData = '0;
    write     = 1'b0;
    ALUSrc    = 1'b0;
    imm       = '0;
    alu_op    = OP_ADD;
    #2;
    checkOutput("reset_rd1", readData1, 32'h0);
    checkOutput("reset_zero", {31'b0, zero}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Asynchronous reset mid-cycle
    regWrite(5'd5, 32'hDEADBEEF);
    applyStimulus(5'd5, 5'd0, 1'b0, 32'h0, OP_ADD);
    checkOutput("x5_written", readData1, 32'hDEADBEEF);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_x5", readData1, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // x0 guard
    applyStimulus(5'd0, 5'd0, 1'b0, 32'h0, OP_ADD);
    regWrite(5'd0, 32'h00001234);
    checkOutput("x0_after_write", readData1, 32'h0);

    // Same-cycle bypass on port 2, then the value persists after the edge
    readReg2  = 5'd1;
    writeReg  = 5'd1;
    writeData = 32'h7;
    write     = 1'b1;
    #1;
    checkOutput("bypass_rd2", readData2, 32'h7);
    @(posedge clk);
    #1;
    write = 1'b0;
    #1;
    checkOutput("x1_stored", readData2, 32'h7);

    // Bypass on port 1
    readReg1  = 5'd6;
    writeReg  = 5'd6;
    writeData = 32'h000000AA;
    write     = 1'b1;
    #1;
    checkOutput("bypass_rd1", readData1, 32'h000000AA);
    @(posedge clk);
    #1;
    write = 1'b0;

    // Arithmetic
    regWrite(5'd1, 32'h7FFFFFFF);
    regWrite(5'd2, 32'h00000001);
    applyStimulus(5'd1, 5'd2, 1'b0, 32'h0, OP_ADD);
    checkOutput("add_wrap", result, 32'h80000000);
    checkOutput("add_zero", {31'b0, zero}, 32'h0);
    applyStimulus(5'd1, 5'd1, 1'b0, 32'h0, OP_SUB);
    checkOutput("sub_self", result, 32'h0);
    checkOutput("sub_zero", {31'b0, zero}, 32'h1);
    applyStimulus(5'd2, 5'd0, 1'b1, 32'hFFFFFFFC, OP_ADD);
    checkOutput("addi_neg", result, 32'hFFFFFFFD);

    // Compares
    regWrite(5'd1, 32'hFFFFFFFF);
    applyStimulus(5'd1, 5'd2, 1'b0, 32'h0, OP_SLT);
    checkOutput("slt", result, 32'h1);
    applyStimulus(5'd1, 5'd2, 1'b0, 32'h0, OP_SLTU);
    checkOutput("sltu", result, 32'h0);

    // Logic
    regWrite(5'd3, 32'hF0F0F0F0);
    regWrite(5'd4, 32'h0FF00FF0);
    applyStimulus(5'd3, 5'd4, 1'b0, 32'h0, OP_AND);
    checkOutput("and", result, 32'h00F000F0);
    applyStimulus(5'd3, 5'd4, 1'b0, 32'h0, OP_OR);
    checkOutput("or", result, 32'hFFF0FFF0);
    applyStimulus(5'd3, 5'd4, 1'b0, 32'h0, OP_XOR);
    checkOutput("xor", result, 32'hFF00FF00);

    // Shifts: amount taken from op2[4:0] only
    regWrite(5'd7, 32'h80000001);
    applyStimulus(5'd7, 5'd0, 1'b1, 32'h00000021, OP_SLL);
    checkOutput("sll", result, 32'h00000002);
    applyStimulus(5'd7, 5'd0, 1'b1, 32'h00000021, OP_SRL);
    checkOutput("srl", result, 32'h40000000);
    applyStimulus(5'd7, 5'd0, 1'b1, 32'h00000021, OP_SRA);
    checkOutput("sra", result, 32'hC0000000);
    regWrite(5'd8, 32'h00000004);
    applyStimulus(5'd7, 5'd8, 1'b0, 32'h0, OP_SRA);
    checkOutput("sra_reg", result, 32'hF8000000);

    // Illegal opcodes
    applyStimulus(5'd3, 5'd4, 1'b0, 32'h0, 4'b1111);
    checkOutput("illegal_1111", result, 32'h0);
    checkOutput("illegal_zero", {31'b0, zero}, 32'h1);
    applyStimulus(5'd3, 5'd4, 1'b0, 32'h0, 4'b0011);
    checkOutput("illegal_0011", result, 32'h0);

    // write=0 must not modify anything
    writeReg  = 5'd3;
    writeData = 32'h12345678;
    write     = 1'b0;
    applyStimulus(5'd3, 5'd4, 1'b0, 32'h0, OP_ADD);
    checkOutput("nowrite_bypass", readData1, 32'hF0F0F0F0);
    @(posedge clk);
    #1;
    checkOutput("nowrite_x3", readData1, 32'hF0F0F0F0);
    checkOutput("nowrite_x4", readData2, 32'h0FF00FF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_alu_regfile_unit
